branch_pred_ctrl: RTL
=====================

# branch_pred_ctrl

Branch prediction controller for the 2nd-arch pipeline. It supplies the taken/not-taken prediction to fetch and tracks each unresolved branch in an in-order queue. When the execute-stage branch unit resolves a branch, the controller updates the 2-bit counter table. On a misprediction it sequences the pipeline flush.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of counter-table entries (64 entries).
- QDEPTH_LOG2, 2, log2 of in-flight branch queue depth (4 entries).
- FLUSH_CYCLES, 2, cycles `flush` stays high after a mispredict (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- pred_req  in  1  fetch presents a branch instruction this cycle.
- pred_pc  in  32  PC of that branch; index = pred_pc[INDEX_BITS+1:2].
- pred_ready  out  1  high when a prediction can be accepted.
- pred_taken  out  1  prediction for pred_pc (combinational from table).
- res_valid  in  1  branch unit resolved the oldest in-flight branch.
- res_mispredict  in  1  resolved outcome differs from the queued prediction.
- flush  out  1  squash younger instructions; redirect fetch.
- redirect_taken  out  1  during flush: 1 = fetch the branch target, 0 = fetch PC+4.
- q_count  out  QDEPTH_LOG2+1  number of in-flight branches.
- err_underflow  out  1  sticky: res_valid arrived while the queue was empty.

## Operation
- Table: 2^INDEX_BITS saturating 2-bit counters. All reset to 2'b01 (weakly not-taken). pred_taken = counter[1].
- Queue entry: {index, predicted}. It is pushed when pred_req && pred_ready.
- On res_valid with the queue non-empty:
  - Pop the head entry.
  - Actual outcome = predicted ^ res_mispredict.
  - Increment the counter at the stored index if taken (saturate at 3); otherwise decrement (saturate at 0).
- States:
  - RUN: normal operation.
  - FLUSH: entered on a popped mispredict.
    - Clear the whole queue, since younger branches are squashed.
    - Load the down-counter with FLUSH_CYCLES.
    - Latch redirect_taken = actual outcome.
    - Decrement each cycle and return to RUN after FLUSH_CYCLES cycles.
- pred_ready = (state==RUN) && (q_count < 2^QDEPTH_LOG2). It does not depend on a same-cycle pop.
- Push and pop in the same cycle without mispredict: both occur and q_count is unchanged.
- Push and mispredict pop in the same cycle: the push is discarded and the queue ends empty.
- res_valid with an empty queue:
  - No table or queue change.
  - Set err_underflow, which stays high until reset.
- res_valid during FLUSH: treated as a stale branch and ignored. It does not set err_underflow.
- Table write and same-index lookup in the same cycle: the lookup returns the pre-update value.

## Timing
- pred_taken: zero latency, combinational from pred_pc.
- Table update: visible to lookups on the cycle after res_valid.
- flush: rises the cycle after the mispredict pop and stays high exactly FLUSH_CYCLES cycles. redirect_taken is valid throughout.
- Reset (async, rstn=0) takes effect immediately, including mid-FLUSH:
  - state = RUN, counters = 01, queue empty, q_count = 0.
  - flush = 0, redirect_taken = 0, err_underflow = 0, pred_ready = 1.
- Queue pointers wrap modulo 2^QDEPTH_LOG2.

## Configuration
- BP_GSHARE_EN defined:
  - A global history register of INDEX_BITS is shifted left by the actual outcome on each non-ignored resolution.
  - Lookup index = pred_pc[INDEX_BITS+1:2] ^ ghr.
  - The queue stores the XORed index.
  - ghr resets to 0 and is not cleared by flush.
- BP_GSHARE_EN undefined: index = PC bits only, and no history register exists.

## Test plan
- Reset, then pred_req with pc=0x40 → pred_taken=0, q_count=1. Next: res_valid, res_mispredict=1 → flush high 2 cycles, redirect_taken=1, q_count=0, counter[16]=2; the next lookup of 0x40 gives pred_taken=1.
- Push 4 branches with no resolution → q_count=4, pred_ready=0; a fifth pred_req is ignored. Then a pop with a simultaneous pred_req → q_count=3, and the request is not accepted.
- Queue holds 2; push and non-mispredict pop in the same cycle → q_count stays 2 and the head entry's counter steps toward its outcome.
- Three consecutive taken resolutions on one index → counter saturates at 3. Three not-taken → saturates at 0.
- res_valid with an empty queue → err_underflow=1 and stays high. rstn low mid-FLUSH → flush=0 immediately and q_count=0.
- With BP_GSHARE_EN: after resolutions taken, taken (ghr=0b000011), a lookup of pc=0x0 uses index 3.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: 2-bit saturating counter table, in-order
// queue of unresolved branches, and a mispredict flush sequencer.
// Optional feature macro: BP_GSHARE_EN (global history XOR-folded into the index).
module branch_pred_ctrl #(
  parameter int INDEX_BITS   = 6,
  parameter int QDEPTH_LOG2  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pred_req,
  input  logic [31:0]            pred_pc,
  output logic                   pred_ready,
  output logic                   pred_taken,
  input  logic                   res_valid,
  input  logic                   res_mispredict,
  output logic                   flush,
  output logic                   redirect_taken,
  output logic [QDEPTH_LOG2:0]   q_count,
  output logic                   err_underflow
);

  localparam int TBL_SIZE = 1 << INDEX_BITS;
  localparam int QDEPTH   = 1 << QDEPTH_LOG2;
  localparam int FCW      = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic                    redir_q, redir_d;
  logic                    err_q;

  logic [1:0]              ctr_q [TBL_SIZE];

  logic [INDEX_BITS-1:0]   qidx_q  [QDEPTH];
  logic                    qpred_q [QDEPTH];
  logic [QDEPTH_LOG2-1:0]  head_q, tail_q;
  logic [QDEPTH_LOG2:0]    count_q;

  logic [INDEX_BITS-1:0]   lk_idx;
  logic [INDEX_BITS-1:0]   upd_idx;
  logic [1:0]              upd_ctr;
  logic [1:0]              ctr_nxt;
  logic                    push, pop, mis, underflow, actual;

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0]   ghr_q;
  assign lk_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_q;
`else
  assign lk_idx = pred_pc[INDEX_BITS+1:2];
`endif

  // Handshake and resolution qualifiers; stale resolutions during FLUSH are dropped
  assign pred_ready = (state_q == RUN) && (count_q < (QDEPTH_LOG2+1)'(QDEPTH));
  assign pred_taken = ctr_q[lk_idx][1];
  assign push       = pred_req && pred_ready;
  assign pop        = res_valid && (state_q == RUN) && (count_q != '0);
  assign underflow  = res_valid && (state_q == RUN) && (count_q == '0);
  assign mis        = pop && res_mispredict;
  assign actual     = qpred_q[head_q] ^ res_mispredict;
  assign upd_idx    = qidx_q[head_q];
  assign upd_ctr    = ctr_q[upd_idx];

  assign flush          = (state_q == FLUSH);
  assign redirect_taken = redir_q;
  assign q_count        = count_q;
  assign err_underflow  = err_q;

  // Saturating step of the resolved branch's counter toward its actual outcome
  always_comb begin
    ctr_nxt = upd_ctr;
    if (actual) begin
      if (upd_ctr != 2'b11) ctr_nxt = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) ctr_nxt = upd_ctr - 2'b01;
    end
  end

  // Next-state logic: a mispredict pop starts a fixed-length flush window
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    redir_d = redir_q;
    case (state_q)
      RUN: begin
        if (mis) begin
          state_d = FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES);
          redir_d = actual;
        end
      end
      FLUSH: begin
        if (fcnt_q <= FCW'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
          redir_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
        redir_d = 1'b0;
      end
    endcase
  end

  // FSM state, flush down-counter, redirect direction and sticky underflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      redir_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      redir_q <= redir_d;
      if (underflow) err_q <= 1'b1;
    end
  end

  // Counter table: reads see the pre-update value, writes land on the next edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TBL_SIZE; i++) ctr_q[i] <= 2'b01;
    end else if (pop) begin
      ctr_q[upd_idx] <= ctr_nxt;
    end
  end

  // Queue pointers and occupancy; a mispredict empties the queue and drops any push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (mis) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + QDEPTH_LOG2'(1);
      if (pop)  head_q <= head_q + QDEPTH_LOG2'(1);
      if (push && !pop)      count_q <= count_q + (QDEPTH_LOG2+1)'(1);
      else if (pop && !push) count_q <= count_q - (QDEPTH_LOG2+1)'(1);
    end
  end

  // Queue payload storage; contents are only meaningful between head and tail
  always_ff @(posedge clk) begin
    if (push && !mis) begin
      qidx_q[tail_q]  <= lk_idx;
      qpred_q[tail_q] <= ctr_q[lk_idx][1];
    end
  end

`ifdef BP_GSHARE_EN
  // Global history shifts in every accepted resolution outcome; flush leaves it intact
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr_q <= '0;
    end else if (pop) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], actual};
    end
  end
`endif

endmodule
